// File: rtl/mem_rsp_pkg.sv
// Shared types and constants for the data-port memory responder.
package mem_rsp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} rsp_state_t;

  localparam int WORD_LSB = 2;
  localparam logic [31:0] ERR_RDATA = '0;

  // Misaligned byte address, or a word index past the end of the backing array.
  function automatic logic addr_error(input logic [31:0] addr, input int unsigned depth_words);
    return (addr[WORD_LSB-1:0] != '0) || ({2'b00, addr[31:WORD_LSB]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data RAM: byte-write enables, synchronous registered read.
module dmem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // rdata returns the word as it was before any write in the same access.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Valid/ready memory responder for the core's data port. One request at a
// time, answered after WAIT_CYCLES wait states from the word-addressed RAM.
module data_mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  rsp_state_t        state;
  logic [3:0]        wait_cnt;
  logic              we_q;
  logic              err_q;
  logic [ADDR_W-1:0] word_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic              commit;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [31:0]       ram_rdata;

  // The access happens on the edge that enters RESP, so a reset landing on
  // that edge (or any earlier one) leaves the array untouched.
  assign commit    = (state == WAIT) && (wait_cnt == LAST_CNT) && !rst;
  assign ram_en    = commit && !err_q;
  assign ram_we    = we_q ? be_q : 4'b0000;
  assign rsp_rdata = (rsp_valid && !we_q && !rsp_err) ? ram_rdata : ERR_RDATA;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      wait_cnt  <= '0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            we_q      <= req_we;
            err_q     <= addr_error(req_addr, DEPTH_WORDS);
            word_q    <= req_addr[ADDR_W+WORD_LSB-1:WORD_LSB];
            wdata_q   <= req_wdata;
            be_q      <= req_be;
            wait_cnt  <= '0;
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        // Always at least one cycle here so the RAM sees the latched request.
        WAIT: begin
          if (wait_cnt == LAST_CNT) begin
            wait_cnt  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_q;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (word_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

endmodule
